// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle control sequencer. It steps each instruction through FETCH,
// DECODE, EXEC, optional MEM and WB. In each state it drives the datapath
// strobes. It waits on a variable-latency data memory through mem_req/mem_ack.
// It reports program completion with done, and it counts active cycles.
//
// Parameters:
//   MCODEBITS  opcode width taken from the instruction register
//   OPWIDTH    ALUOp output width (must be >= 3; upper bits are zero-extended)
//   CNTW       cycle counter width
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        begin / restart program execution (IDLE or HALT only)
//   instr        opcode field of the instruction register
//   last_instr   the instruction in IR is the final one of the program
//   mem_ack      data memory has completed the current access
//   ir_load      load instruction register (FETCH)
//   pc_en        advance / branch program counter (WB)
//   Branch       PC takes the branch path when the datapath condition holds
//   ALUSrc       1: immediate operand, 0: register operand
//   ALUOp        ALU operation select (all-ones = pass a)
//   RegWrite     register file write enable
//   MemtoReg     write-back source is memory
//   MemWrite     store strobe, only meaningful while mem_req=1
//   mem_req      data memory access request
//   done         program finished (HALT)
//   cycle_count  saturating count of cycles spent outside IDLE/HALT
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int MCODEBITS = 3,
    parameter int OPWIDTH   = 3,
    parameter int CNTW      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 last_instr,
    input  logic                 mem_ack,
    output logic                 ir_load,
    output logic                 pc_en,
    output logic                 Branch,
    output logic                 ALUSrc,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 mem_req,
    output logic                 done,
    output logic [CNTW-1:0]      cycle_count
);

    // Opcode encodings
    localparam logic [MCODEBITS-1:0] OP_ADD   = MCODEBITS'(3'd0);
    localparam logic [MCODEBITS-1:0] OP_ROR   = MCODEBITS'(3'd1);
    localparam logic [MCODEBITS-1:0] OP_NAND  = MCODEBITS'(3'd2);
    localparam logic [MCODEBITS-1:0] OP_LOAD  = MCODEBITS'(3'd3);
    localparam logic [MCODEBITS-1:0] OP_STORE = MCODEBITS'(3'd4);
    localparam logic [MCODEBITS-1:0] OP_BNE   = MCODEBITS'(3'd6);
    localparam logic [MCODEBITS-1:0] OP_SET   = MCODEBITS'(3'd7);

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    // ALU select for an opcode. The 3-bit code is zero-extended to OPWIDTH.
    function automatic logic [OPWIDTH-1:0] alu_sel(input logic [MCODEBITS-1:0] op);
        logic [OPWIDTH-1:0] sel;
        sel = '0;
        case (op)
            OP_ADD:  sel[2:0] = 3'b000;
            OP_ROR:  sel[2:0] = 3'b001;
            OP_NAND: sel[2:0] = 3'b010;
            OP_BNE:  sel[2:0] = 3'b011;
            default: sel[2:0] = 3'b111;
        endcase
        return sel;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic [MCODEBITS-1:0]   op_r;
    logic [MCODEBITS-1:0]   op_next_s;
    logic                   last_r;
    logic                   last_next_s;
    logic [CNTW-1:0]        count_r;
    logic                   count_en_s;

    logic                   ir_load_s;
    logic                   pc_en_s;
    logic                   branch_s;
    logic                   alusrc_s;
    logic [OPWIDTH-1:0]     aluop_s;
    logic                   regwrite_s;
    logic                   memtoreg_s;
    logic                   memwrite_s;
    logic                   mem_req_s;
    logic                   done_s;

    logic                   ir_load_r;
    logic                   pc_en_r;
    logic                   branch_r;
    logic                   alusrc_r;
    logic [OPWIDTH-1:0]     aluop_r;
    logic                   regwrite_r;
    logic                   memtoreg_r;
    logic                   memwrite_r;
    logic                   mem_req_r;
    logic                   done_r;

    // Next-state logic, plus capture of the opcode and last flag in DECODE
    always_comb begin
        state_next_s = state_r;
        op_next_s    = op_r;
        last_next_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_next_s = ST_DECODE;
            end
            ST_DECODE: begin
                op_next_s    = instr;
                last_next_s  = last_instr;
                state_next_s = ST_EXEC;
            end
            ST_EXEC: begin
                if ((op_r == OP_LOAD) || (op_r == OP_STORE)) begin
                    state_next_s = ST_MEM;
                end else begin
                    state_next_s = ST_WB;
                end
            end
            ST_MEM: begin
                // No timeout: the memory is trusted to answer eventually
                if (mem_ack) begin
                    state_next_s = ST_WB;
                end else begin
                    state_next_s = ST_MEM;
                end
            end
            ST_WB: begin
                if (last_r) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state and opcode. Registering this keeps
    // the outputs equal to the decode of the current state, glitch-free.
    // mem_req therefore drops on the same edge that leaves MEM on mem_ack.
    always_comb begin
        ir_load_s  = 1'b0;
        pc_en_s    = 1'b0;
        branch_s   = 1'b0;
        alusrc_s   = 1'b0;
        aluop_s    = '1;
        regwrite_s = 1'b0;
        memtoreg_s = 1'b0;
        memwrite_s = 1'b0;
        mem_req_s  = 1'b0;
        done_s     = 1'b0;
        case (state_next_s)
            ST_FETCH: begin
                ir_load_s = 1'b1;
            end
            ST_EXEC: begin
                aluop_s  = alu_sel(op_next_s);
                alusrc_s = (op_next_s == OP_SET);
            end
            ST_MEM: begin
                mem_req_s  = 1'b1;
                memwrite_s = (op_next_s == OP_STORE);
                memtoreg_s = (op_next_s == OP_LOAD);
            end
            ST_WB: begin
                pc_en_s    = 1'b1;
                regwrite_s = (op_next_s != OP_STORE) && (op_next_s != OP_BNE);
                memtoreg_s = (op_next_s == OP_LOAD);
                branch_s   = (op_next_s == OP_BNE);
                aluop_s    = alu_sel(op_next_s);
                alusrc_s   = (op_next_s == OP_SET);
            end
            ST_HALT: begin
                done_s = 1'b1;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // State, opcode and last-instruction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            op_r    <= '0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            op_r    <= op_next_s;
            last_r  <= last_next_s;
        end
    end

    // Output registers. Reset leaves every strobe low and ALUOp at pass-a.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_load_r  <= 1'b0;
            pc_en_r    <= 1'b0;
            branch_r   <= 1'b0;
            alusrc_r   <= 1'b0;
            aluop_r    <= '1;
            regwrite_r <= 1'b0;
            memtoreg_r <= 1'b0;
            memwrite_r <= 1'b0;
            mem_req_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            ir_load_r  <= ir_load_s;
            pc_en_r    <= pc_en_s;
            branch_r   <= branch_s;
            alusrc_r   <= alusrc_s;
            aluop_r    <= aluop_s;
            regwrite_r <= regwrite_s;
            memtoreg_r <= memtoreg_s;
            memwrite_r <= memwrite_s;
            mem_req_r  <= mem_req_s;
            done_r     <= done_s;
        end
    end

    assign count_en_s = (state_r != ST_IDLE) && (state_r != ST_HALT);

    // Saturating count of active cycles. The count holds at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (count_en_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNTW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign ir_load     = ir_load_r;
    assign pc_en       = pc_en_r;
    assign Branch      = branch_r;
    assign ALUSrc      = alusrc_r;
    assign ALUOp       = aluop_r;
    assign RegWrite    = regwrite_r;
    assign MemtoReg    = memtoreg_r;
    assign MemWrite    = memwrite_r;
    assign mem_req     = mem_req_r;
    assign done        = done_r;
    assign cycle_count = count_r;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Two instances of multicycle_control share the same stimulus. One uses the
// default CNTW=16 and the other uses CNTW=3, so that counter saturation shows.
// An instruction-timeline model predicts every output on every cycle. Directed
// literal expectations pin that model.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] instr;
    logic       last_instr;
    logic       mem_ack;

    logic       a_ir_load, a_pc_en, a_Branch, a_ALUSrc, a_RegWrite;
    logic       a_MemtoReg, a_MemWrite, a_mem_req, a_done;
    logic [2:0] a_ALUOp;
    logic [15:0] a_cycle_count;

    logic       b_ir_load, b_pc_en, b_Branch, b_ALUSrc, b_RegWrite;
    logic       b_MemtoReg, b_MemWrite, b_mem_req, b_done;
    logic [2:0] b_ALUOp;
    logic [2:0] b_cycle_count;

    multicycle_control #(.MCODEBITS(3), .OPWIDTH(3), .CNTW(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .last_instr(last_instr), .mem_ack(mem_ack),
        .ir_load(a_ir_load), .pc_en(a_pc_en), .Branch(a_Branch),
        .ALUSrc(a_ALUSrc), .ALUOp(a_ALUOp), .RegWrite(a_RegWrite),
        .MemtoReg(a_MemtoReg), .MemWrite(a_MemWrite), .mem_req(a_mem_req),
        .done(a_done), .cycle_count(a_cycle_count)
    );

    multicycle_control #(.MCODEBITS(3), .OPWIDTH(3), .CNTW(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .last_instr(last_instr), .mem_ack(mem_ack),
        .ir_load(b_ir_load), .pc_en(b_pc_en), .Branch(b_Branch),
        .ALUSrc(b_ALUSrc), .ALUOp(b_ALUOp), .RegWrite(b_RegWrite),
        .MemtoReg(b_MemtoReg), .MemWrite(b_MemWrite), .mem_req(b_mem_req),
        .done(b_done), .cycle_count(b_cycle_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Counts of DUT strobes over time. The flow takes snapshots of these.
    int cnt_mreq = 0;
    int cnt_mw   = 0;
    int cnt_br   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-timeline model ----------------
    // mode: 0 idle, 1 running, 2 halted.
    // t is the cycle index within the current instruction (0 = fetch cycle).
    // wb_at is the index of the write-back cycle. It is -1 while a memory
    // access is still open.
    int m_mode  = 0;
    int m_t     = 0;
    int m_wb_at = 3;
    int m_op    = 0;
    int m_last  = 0;
    int m_cnt   = 0;

    function automatic bit is_mem(input int op);
        return (op == 3) || (op == 4);
    endfunction

    function automatic int alu_of(input int op);
        case (op)
            0: return 0;
            1: return 1;
            2: return 2;
            6: return 3;
            default: return 7;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode <= 0; m_t <= 0; m_wb_at <= 3; m_op <= 0; m_last <= 0; m_cnt <= 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode <= 1; m_t <= 0; m_wb_at <= 3;
            end
        end else begin
            m_cnt <= m_cnt + 1;
            if (m_t == 1) begin
                m_op    <= int'(instr);
                m_last  <= int'(last_instr);
                m_wb_at <= is_mem(int'(instr)) ? -1 : 3;
            end
            if (m_t >= 3 && m_wb_at < 0 && mem_ack) m_wb_at <= m_t + 1;
            if (m_t == m_wb_at) begin
                if (m_last != 0) m_mode <= 2;
                else begin
                    m_t <= 0; m_wb_at <= 3;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    // Compare process: checks both DUTs against the model on every negedge
    initial begin
        logic       e_ir, e_pc, e_br, e_src, e_rw, e_m2r, e_mw, e_mreq, e_done;
        logic [2:0] e_alu;
        int         e_cnt_a, e_cnt_b;
        forever begin
            @(negedge clk);
            if (a_mem_req === 1'b1) cnt_mreq++;
            if (a_mem_req === 1'b1 && a_MemWrite === 1'b1) cnt_mw++;
            if (a_Branch === 1'b1) cnt_br++;
            if (chk_en) begin
                e_ir = 0; e_pc = 0; e_br = 0; e_src = 0; e_rw = 0;
                e_m2r = 0; e_mw = 0; e_mreq = 0; e_done = 0; e_alu = 3'b111;
                if (m_mode == 2) e_done = 1;
                if (m_mode == 1) begin
                    if (m_t == 0) e_ir = 1;
                    if (m_t == 2) begin
                        e_alu = 3'(alu_of(m_op)); e_src = (m_op == 7);
                    end
                    if (m_t >= 3 && (m_wb_at < 0 || m_t < m_wb_at)) begin
                        e_mreq = 1; e_mw = (m_op == 4); e_m2r = (m_op == 3);
                    end
                    if (m_t == m_wb_at) begin
                        e_pc = 1; e_rw = !(m_op == 4 || m_op == 6);
                        e_m2r = (m_op == 3); e_br = (m_op == 6);
                        e_alu = 3'(alu_of(m_op)); e_src = (m_op == 7);
                    end
                end
                e_cnt_a = (m_cnt > 65535) ? 65535 : m_cnt;
                e_cnt_b = (m_cnt > 7) ? 7 : m_cnt;
                chk("a.ir_load",  32'(a_ir_load),  32'(e_ir));
                chk("a.pc_en",    32'(a_pc_en),    32'(e_pc));
                chk("a.Branch",   32'(a_Branch),   32'(e_br));
                chk("a.ALUSrc",   32'(a_ALUSrc),   32'(e_src));
                chk("a.ALUOp",    32'(a_ALUOp),    32'(e_alu));
                chk("a.RegWrite", 32'(a_RegWrite), 32'(e_rw));
                chk("a.MemtoReg", 32'(a_MemtoReg), 32'(e_m2r));
                chk("a.MemWrite", 32'(a_MemWrite), 32'(e_mw));
                chk("a.mem_req",  32'(a_mem_req),  32'(e_mreq));
                chk("a.done",     32'(a_done),     32'(e_done));
                chk("a.cycle_count", 32'(a_cycle_count), 32'(e_cnt_a));
                chk("b.ir_load",  32'(b_ir_load),  32'(e_ir));
                chk("b.pc_en",    32'(b_pc_en),    32'(e_pc));
                chk("b.Branch",   32'(b_Branch),   32'(e_br));
                chk("b.ALUSrc",   32'(b_ALUSrc),   32'(e_src));
                chk("b.ALUOp",    32'(b_ALUOp),    32'(e_alu));
                chk("b.RegWrite", 32'(b_RegWrite), 32'(e_rw));
                chk("b.MemtoReg", 32'(b_MemtoReg), 32'(e_m2r));
                chk("b.MemWrite", 32'(b_MemWrite), 32'(e_mw));
                chk("b.mem_req",  32'(b_mem_req),  32'(e_mreq));
                chk("b.done",     32'(b_done),     32'(e_done));
                chk("b.cycle_count", 32'(b_cycle_count), 32'(e_cnt_b));
            end
        end
    end

    // One clock, then settle just after the active edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in a FETCH cycle. Runs one instruction and returns in the cycle
    // after WB (the next FETCH or HALT). lat is the number of MEM cycles,
    // with mem_ack raised in the last of them.
    task automatic run_instr(input logic [2:0] op, input logic last, input int lat);
        instr = op;
        last_instr = last;
        step();                     // DECODE
        step();                     // EXEC
        step();                     // MEM1 or WB
        if (op == 3'd3 || op == 3'd4) begin
            for (int i = 1; i <= lat; i++) begin
                if (i == lat) mem_ack = 1'b1;
                step();
            end
            mem_ack = 1'b0;         // now in WB
        end
        step();                     // next FETCH / HALT
    endtask

    initial begin
        int s1, s2;
        reset = 1'b1; start = 1'b0; instr = 3'd0; last_instr = 1'b0; mem_ack = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        // reset / idle state
        chk("rst.cycle_count", 32'(a_cycle_count), 32'd0);
        chk("rst.done",        32'(a_done),        32'd0);
        chk("rst.ALUOp",       32'(a_ALUOp),       32'd7);
        chk("rst.mem_req",     32'(a_mem_req),     32'd0);

        // add: fetch one cycle after start, write-back in cycle 4
        start = 1'b1; instr = 3'd0; last_instr = 1'b0;
        step();
        start = 1'b0;
        chk("add.ir_load",  32'(a_ir_load), 32'd1);
        step();
        step();
        chk("add.ALUOp",    32'(a_ALUOp),   32'd0);
        step();
        chk("add.RegWrite", 32'(a_RegWrite), 32'd1);
        chk("add.pc_en",    32'(a_pc_en),    32'd1);
        step();
        chk("add.next_fetch", 32'(a_ir_load), 32'd1);
        chk("add.count",      32'(a_cycle_count), 32'd4);

        // load with 3 MEM cycles: 7 active cycles
        s1 = cnt_mreq;
        run_instr(3'd3, 1'b0, 3);
        chk("load.mem_req_cycles", 32'(cnt_mreq - s1), 32'd3);
        chk("load.count",          32'(a_cycle_count), 32'd11);

        // store acked on MEM entry: 5 active cycles
        s1 = cnt_mreq; s2 = cnt_mw;
        run_instr(3'd4, 1'b0, 1);
        chk("store.mem_req_cycles",  32'(cnt_mreq - s1), 32'd1);
        chk("store.memwrite_cycles", 32'(cnt_mw - s2),   32'd1);
        chk("store.count",           32'(a_cycle_count), 32'd16);

        // remaining ALU-type ops
        run_instr(3'd1, 1'b0, 0);
        run_instr(3'd2, 1'b0, 0);
        run_instr(3'd5, 1'b0, 0);
        run_instr(3'd7, 1'b0, 0);
        chk("alu_ops.count", 32'(a_cycle_count), 32'd32);

        // bne as last instruction, then HALT
        s1 = cnt_br;
        run_instr(3'd6, 1'b1, 0);
        chk("bne.done",      32'(a_done),         32'd1);
        chk("bne.count",     32'(a_cycle_count),  32'd36);
        chk("bne.branch",    32'(cnt_br - s1),    32'd1);
        step();
        step();
        chk("halt.frozen",   32'(a_cycle_count),  32'd36);
        chk("halt.b_sat",    32'(b_cycle_count),  32'd7);

        // fresh start: single bne takes 4 cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2.count", 32'(a_cycle_count), 32'd0);
        chk("rst2.done",  32'(a_done),        32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(3'd6, 1'b1, 0);
        chk("bne_fresh.count", 32'(a_cycle_count), 32'd4);
        chk("bne_fresh.done",  32'(a_done),        32'd1);

        // restart from HALT with start held high through the next instruction
        start = 1'b1;
        step();
        chk("restart.done",    32'(a_done),    32'd0);
        chk("restart.ir_load", 32'(a_ir_load), 32'd1);
        run_instr(3'd0, 1'b0, 0);
        start = 1'b0;
        chk("restart.count", 32'(a_cycle_count), 32'd8);

        // reset while waiting in MEM, then a late mem_ack
        instr = 3'd3; last_instr = 1'b0;
        step(); step(); step(); step();
        chk("midmem.mem_req", 32'(a_mem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midmem_rst.mem_req", 32'(a_mem_req),     32'd0);
        chk("midmem_rst.count",   32'(a_cycle_count), 32'd0);
        chk("midmem_rst.done",    32'(a_done),        32'd0);
        mem_ack = 1'b1;
        step(); step();
        mem_ack = 1'b0;
        chk("late_ack.ir_load", 32'(a_ir_load),     32'd0);
        chk("late_ack.mem_req", 32'(a_mem_req),     32'd0);
        chk("late_ack.count",   32'(a_cycle_count), 32'd0);

        // three adds: 12 cycles, CNTW=3 instance saturates at 7
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(3'd0, 1'b0, 0);
        run_instr(3'd0, 1'b0, 0);
        run_instr(3'd0, 1'b1, 0);
        chk("sat.a_count", 32'(a_cycle_count), 32'd12);
        chk("sat.b_count", 32'(b_cycle_count), 32'd7);
        chk("sat.b_done",  32'(b_done),        32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sat_restart.b_done",    32'(b_done),        32'd0);
        chk("sat_restart.b_ir_load", 32'(b_ir_load),     32'd1);
        chk("sat_restart.b_count",   32'(b_cycle_count), 32'd7);
        run_instr(3'd2, 1'b1, 0);
        chk("sat_end.a_count", 32'(a_cycle_count), 32'd16);
        chk("sat_end.b_count", 32'(b_cycle_count), 32'd7);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
